// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 Set-2 scancode front end: prefix bytes,
// decoder states and the packed key-event record stored in the event FIFO.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } dec_state_e;

    // "repeat" is a keyword, so the repeat flag is stored as rpt.
    typedef struct packed {
        logic       rpt;
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 serial frame receiver: synchronises the raw lines, samples on falling
// ps2_clk edges, checks start/parity/stop and aborts stalled partial frames.
module ps2_frame_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       rx_byte_vld,
    output logic       rx_err
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic                   vld_q, vld_d;
    logic                   err_q, err_d;
    logic                   fall;
    logic                   din;

    assign din  = dat_sync_q[SYNC_STAGES-1];
    assign fall = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d = clk_sync_q[SYNC_STAGES-1];
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        idle_d     = '0;
        vld_d      = 1'b0;
        err_d      = 1'b0;
        if (fall) begin
            if (bit_cnt_q == 4'd0) begin
                if (!din) begin
                    bit_cnt_d = 4'd1;
                    par_d     = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end else if (bit_cnt_q <= 4'd8) begin
                shift_d   = {din, shift_q[7:1]};
                par_d     = par_q ^ din;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd9) begin
                par_d     = par_q ^ din;
                bit_cnt_d = 4'd10;
            end else begin
                // Stop bit: par_q now holds the XOR of data and parity, which must be odd.
                bit_cnt_d = 4'd0;
                if (din && par_q) vld_d = 1'b1;
                else              err_d = 1'b1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                bit_cnt_d = 4'd0;
                err_d     = 1'b1;
            end else begin
                idle_d = idle_q + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            par_q      <= 1'b0;
            idle_q     <= '0;
            vld_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            idle_q     <= idle_d;
            vld_q      <= vld_d;
            err_q      <= err_d;
        end
    end

    assign rx_byte     = shift_q;
    assign rx_byte_vld = vld_q;
    assign rx_err      = err_q;

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 keyboard front end: frame receiver, Set-2 prefix decoder with typematic
// repeat tracking, and a valid/ready event FIFO toward the CPU side.
module ps2_scancode_decoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_break,
    output logic                          evt_repeat,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          err_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [7:0] rx_byte;
    logic       rx_vld;
    logic       rx_err;

    ps2_frame_rx #(
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .rx_byte     (rx_byte),
        .rx_byte_vld (rx_vld),
        .rx_err      (rx_err)
    );

    dec_state_e       state_q, state_d;
    logic             held_vld_q, held_vld_d;
    logic [8:0]       held_key_q, held_key_d;
    logic             emit, emit_ext, emit_brk;
    logic             key_match;
    ps2_evt_t         push_evt;

    ps2_evt_t         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             frame_err_q, frame_err_d;
    logic             full, pop, push_ok;
    ps2_evt_t         head;

    always_comb begin
        state_d  = state_q;
        emit     = 1'b0;
        emit_ext = 1'b0;
        emit_brk = 1'b0;
        if (rx_err) begin
            state_d = ST_IDLE;
        end else if (rx_vld) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rx_byte == PS2_EXT)      state_d = ST_EXT;
                    else if (rx_byte == PS2_BRK) state_d = ST_BRK;
                    else                         emit = 1'b1;
                end
                ST_EXT: begin
                    if (rx_byte == PS2_BRK)      state_d = ST_EXT_BRK;
                    else if (rx_byte != PS2_EXT) begin
                        emit     = 1'b1;
                        emit_ext = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: begin
                    emit     = 1'b1;
                    emit_ext = 1'b1;
                    emit_brk = 1'b1;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    // A make of the key already held is a typematic repeat; only its own break releases it.
    always_comb begin
        held_vld_d    = held_vld_q;
        held_key_d    = held_key_q;
        key_match     = held_vld_q && (held_key_q == {emit_ext, rx_byte});
        push_evt      = '0;
        push_evt.ext  = emit_ext;
        push_evt.brk  = emit_brk;
        push_evt.code = rx_byte;
        if (emit) begin
            if (emit_brk) begin
                if (key_match) held_vld_d = 1'b0;
            end else begin
                push_evt.rpt = key_match;
                held_vld_d   = 1'b1;
                held_key_d   = {emit_ext, rx_byte};
            end
        end
    end

    always_comb begin
        full        = (count_q == CNT_W'(FIFO_DEPTH));
        pop         = evt_valid & evt_ready;
        push_ok     = emit & (~full | pop);
        wr_ptr_d    = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        overflow_d  = err_clr ? 1'b0 : (overflow_q | (emit & ~push_ok));
        frame_err_d = err_clr ? 1'b0 : (frame_err_q | rx_err);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_evt;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q     <= ST_IDLE;
            held_vld_q  <= 1'b0;
            held_key_q  <= 9'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            held_vld_q  <= held_vld_d;
            held_key_q  <= held_key_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Head is masked while empty so the outputs read zero instead of stale storage.
    assign evt_valid  = (count_q != '0);
    assign head       = evt_valid ? mem_q[rd_ptr_q] : '0;
    assign evt_code   = head.code;
    assign evt_ext    = head.ext;
    assign evt_break  = head.brk;
    assign evt_repeat = head.rpt;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed scenarios plus
// randomized scancode streams against a behavioural key-event model.
module tb_ps2_scancode_decoder;

    localparam int DEPTH = 8;
    localparam int TMO   = 300;
    localparam int HALF  = 8;

    logic       clk = 1'b0;
    logic       clrn;
    logic       ps2_clk;
    logic       ps2_data;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_repeat;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       frame_err;
    logic       err_clr;

    ps2_scancode_decoder #(
        .FIFO_DEPTH     (DEPTH),
        .SYNC_STAGES    (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_break  (evt_break),
        .evt_repeat (evt_repeat),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .err_clr    (err_clr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: events are {repeat, ext, break, code}; prefixes are plain flags.
    logic [10:0] exp_q[$];
    bit          m_ext, m_brk, m_held_vld, m_ovf, m_ferr;
    logic [8:0]  m_held;

    function automatic void model_reset();
        exp_q.delete();
        m_ext = 0; m_brk = 0; m_held_vld = 0; m_ovf = 0; m_ferr = 0; m_held = '0;
    endfunction

    function automatic void model_push(input logic [10:0] ev);
        if (exp_q.size() < DEPTH) exp_q.push_back(ev);
        else                      m_ovf = 1;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        bit rpt;
        if (m_brk) begin
            if (m_held_vld && m_held == {m_ext, b}) m_held_vld = 0;
            model_push({1'b0, m_ext, 1'b1, b});
            m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            rpt = m_held_vld && (m_held == {m_ext, b});
            m_held = {m_ext, b};
            m_held_vld = 1;
            model_push({rpt, m_ext, 1'b0, b});
            m_ext = 0;
        end
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 11);
        model_byte(b);
    endtask

    task automatic pop_event(output logic [10:0] ev, output bit ok);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (evt_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        ev = {evt_repeat, evt_ext, evt_break, evt_code};
        if (ok) begin
            evt_ready = 1'b1;
            @(negedge clk);
            evt_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        clrn = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        ps2_clk = 1'b1; ps2_data = 1'b1; evt_ready = 1'b0; err_clr = 1'b0;
        clrn = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({evt_valid, fifo_count, overflow, frame_err, evt_code, evt_ext, evt_break, evt_repeat} !== '0)
            $display("FAIL reset_in: got v=%b cnt=%0d ovf=%b ferr=%b code=%h required all zero",
                     evt_valid, fifo_count, overflow, frame_err, evt_code);
        else n_pass++;
        clrn = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        n_checks++;
        if ({evt_valid, fifo_count, overflow, frame_err, evt_code, evt_ext, evt_break, evt_repeat} !== '0)
            $display("FAIL reset_out: got v=%b cnt=%0d ovf=%b ferr=%b required all zero",
                     evt_valid, fifo_count, overflow, frame_err);
        else n_pass++;
    endtask

    task automatic test_press_release();
        logic [10:0] exp [2];
        logic [10:0] ev;
        bit ok;
        exp[0] = 11'h01C; exp[1] = 11'h11C;
        send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
        n_checks++;
        if (fifo_count !== 4'd2) $display("FAIL press_count: got %0d required 2", fifo_count);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            pop_event(ev, ok);
            n_checks++;
            if (!ok || ev !== exp[i]) $display("FAIL press_evt%0d: got %h ok=%0d required %h", i, ev, ok, exp[i]);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_extended();
        logic [10:0] exp [2];
        logic [10:0] ev;
        bit ok;
        exp[0] = 11'h275; exp[1] = 11'h375;
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        for (int i = 0; i < 2; i++) begin
            pop_event(ev, ok);
            n_checks++;
            if (!ok || ev !== exp[i]) $display("FAIL ext_evt%0d: got %h ok=%0d required %h", i, ev, ok, exp[i]);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_repeat();
        logic [10:0] exp [5];
        logic [10:0] ev;
        bit ok;
        exp[0] = 11'h01C; exp[1] = 11'h41C; exp[2] = 11'h41C; exp[3] = 11'h11C; exp[4] = 11'h01C;
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C); send_byte(8'h1C);
        for (int i = 0; i < 5; i++) begin
            pop_event(ev, ok);
            n_checks++;
            if (!ok || ev !== exp[i]) $display("FAIL repeat_evt%0d: got %h ok=%0d required %h", i, ev, ok, exp[i]);
            else n_pass++;
        end
        exp_q.delete();
    endtask

    task automatic test_parity_err();
        logic [10:0] ev;
        bit ok;
        send_frame(8'h1C, 1'b1, 11);
        m_ext = 0; m_brk = 0;
        n_checks++;
        if (frame_err !== 1'b1 || fifo_count !== 4'd0)
            $display("FAIL parity_err: got ferr=%b cnt=%0d required ferr=1 cnt=0", frame_err, fifo_count);
        else n_pass++;
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        n_checks++;
        if (frame_err !== 1'b0) $display("FAIL parity_clr: got %b required 0", frame_err);
        else n_pass++;
        send_byte(8'h1B);
        pop_event(ev, ok);
        n_checks++;
        if (!ok || ev !== 11'h01B) $display("FAIL parity_next: got %h ok=%0d required 01b", ev, ok);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_overflow();
        logic [10:0] ev;
        bit ok;
        for (int i = 0; i <= DEPTH; i++) send_byte(8'h10 + 8'(i));
        n_checks++;
        if (fifo_count !== 4'(DEPTH) || overflow !== 1'b1)
            $display("FAIL ovf_state: got cnt=%0d ovf=%b required cnt=%0d ovf=1", fifo_count, overflow, DEPTH);
        else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            pop_event(ev, ok);
            n_checks++;
            if (!ok || ev !== {3'b000, 8'h10 + 8'(i)})
                $display("FAIL ovf_order%0d: got %h ok=%0d required %h", i, ev, ok, {3'b000, 8'h10 + 8'(i)});
            else n_pass++;
        end
        n_checks++;
        if (evt_valid !== 1'b0) $display("FAIL ovf_empty: got valid=%b required 0", evt_valid);
        else n_pass++;
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) $display("FAIL ovf_clr: got %b required 0", overflow);
        else n_pass++;
        exp_q.delete(); m_ovf = 0;
    endtask

    task automatic test_timeout();
        logic [10:0] ev;
        bit ok;
        send_frame(8'h00, 1'b0, 6);
        repeat (TMO + 20) @(negedge clk);
        n_checks++;
        if (frame_err !== 1'b1 || fifo_count !== 4'd0)
            $display("FAIL timeout_err: got ferr=%b cnt=%0d required ferr=1 cnt=0", frame_err, fifo_count);
        else n_pass++;
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        send_byte(8'h29);
        n_checks++;
        if (fifo_count !== 4'd1 || frame_err !== 1'b0)
            $display("FAIL timeout_cnt: got cnt=%0d ferr=%b required cnt=1 ferr=0", fifo_count, frame_err);
        else n_pass++;
        pop_event(ev, ok);
        n_checks++;
        if (!ok || ev !== 11'h029) $display("FAIL timeout_evt: got %h ok=%0d required 029", ev, ok);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [10:0] ev;
        bit ok;
        send_byte(8'hE0); send_byte(8'hF0);
        do_reset();
        send_byte(8'h29);
        pop_event(ev, ok);
        n_checks++;
        if (!ok || ev !== 11'h029) $display("FAIL reset_mid: got %h ok=%0d required 029", ev, ok);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic [10:0] exp;
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(8'h01, 8'h7F)));
        evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (evt_valid !== 1'b1 || {evt_repeat, evt_ext, evt_break, evt_code} !== exp)
                $display("FAIL b2b_evt%0d: got v=%b %h required %h", i, evt_valid,
                         {evt_repeat, evt_ext, evt_break, evt_code}, exp);
            else n_pass++;
            @(negedge clk);
        end
        evt_ready = 1'b0;
        n_checks++;
        if (evt_valid !== 1'b0 || fifo_count !== 4'd0)
            $display("FAIL b2b_empty: got v=%b cnt=%0d required 0", evt_valid, fifo_count);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [10:0] ev, exp;
        bit ok;
        int r;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                send_frame(8'($urandom_range(0, 255)), 1'b1, 11);
                m_ext = 0; m_brk = 0; m_ferr = 1;
            end else if (r == 1) send_byte(8'hE0);
            else if (r == 2)     send_byte(8'hF0);
            else                 send_byte(8'($urandom_range(8'h10, 8'h13)));
            if (it % 5 == 4) begin
                while (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    pop_event(ev, ok);
                    n_checks++;
                    if (!ok || ev !== exp) $display("FAIL rand_evt%0d: got %h ok=%0d required %h", it, ev, ok, exp);
                    else n_pass++;
                end
                n_checks++;
                if (evt_valid !== 1'b0 || overflow !== m_ovf || frame_err !== m_ferr)
                    $display("FAIL rand_flags%0d: got v=%b ovf=%b ferr=%b required v=0 ovf=%b ferr=%b",
                             it, evt_valid, overflow, frame_err, m_ovf, m_ferr);
                else n_pass++;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_press_release();
        test_extended();
        test_repeat();
        test_parity_err();
        test_overflow();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Parametrised PS/2 keyboard front end. It receives serial frames from the keyboard, checks them, and decodes Set-2 scancode sequences (E0 extended prefix, F0 break prefix) into single key events. Each event carries make/break, extended and auto-repeat flags, and is buffered in an event FIFO with a valid/ready handshake toward the CPU-side keyboard device. It supersedes the raw byte-shifting keyboard wrapper in the npc keyboard path.

## Interface
Parameters:
- FIFO_DEPTH, 8: number of buffered events; power of two, at least 2.
- SYNC_STAGES, 2: synchroniser flops on ps2_clk and ps2_data; at least 2.
- TIMEOUT_CYCLES, 50000: number of clk cycles without a ps2_clk falling edge that aborts a partial frame.

Ports:
- clk, in, 1: system clock.
- clrn, in, 1: reset, asynchronous and active-low.
- ps2_clk, in, 1: raw PS/2 clock, asynchronous to clk.
- ps2_data, in, 1: raw PS/2 data, asynchronous to clk.
- evt_valid, out, 1: FIFO head holds an event.
- evt_ready, in, 1: consumer accepts the head event.
- evt_code, out, 8: scancode byte with prefixes removed.
- evt_ext, out, 1: sequence contained an E0 prefix.
- evt_break, out, 1: key release (F0 seen).
- evt_repeat, out, 1: typematic repeat of the currently held key.
- fifo_count, out, $clog2(FIFO_DEPTH)+1: number of events currently buffered.
- overflow, out, 1: sticky; an event was dropped because the FIFO was full.
- frame_err, out, 1: sticky; bad start, stop or parity bit, or a frame timeout.
- err_clr, in, 1: synchronous clear of overflow and frame_err.

## Operation
- Frame receiver:
  - Sample on each synchronised ps2_clk falling edge.
  - 11-bit frame: start=0, 8 data bits LSB first, odd parity, stop=1.
  - On a bad start, parity or stop bit: discard the byte, set frame_err, return to idle.
  - Timeout: bit count non-zero and the idle counter reaches TIMEOUT_CYCLES → bit count cleared, frame_err set.
- Decoder FSM, states IDLE, EXT, BRK, EXT_BRK:
  - IDLE: E0→EXT, F0→BRK, any other byte → emit {ext=0, break=0}, stay IDLE.
  - EXT: F0→EXT_BRK, E0→stay EXT, any other byte → emit {ext=1, break=0}, go IDLE.
  - BRK: emit {ext=0, break=1}, go IDLE.
  - EXT_BRK: emit {ext=1, break=1}, go IDLE.
  - A frame error or timeout forces IDLE.
- Repeat tracking, registers held_vld and held_key={ext,code}:
  - Make with held_vld=1 and matching key → evt_repeat=1.
  - Any other make → evt_repeat=0 and held_key loaded.
  - Break matching held_key → held_vld cleared.
  - Break of any other key → no change.
  - Breaks always have evt_repeat=0.
- Event FIFO:
  - Entry is {repeat, ext, break, code}, 11 bits.
  - Push when the FSM emits an event.
  - Pop when evt_valid && evt_ready.
  - When full, a push succeeds only if a pop happens in the same cycle; otherwise the event is dropped and overflow is set.
  - Pointer wrap is modulo FIFO_DEPTH.
- err_clr has priority over a same-cycle set.

## Timing
- Reset values:
  - evt_valid=0, fifo_count=0, overflow=0, frame_err=0.
  - evt_code/ext/break/repeat=0.
  - FSM in IDLE, held_vld=0, bit count 0.
- Edge detection latency: SYNC_STAGES+1 cycles from the raw ps2_clk fall.
- Stop-bit edge detected at cycle T:
  - byte valid at T+1;
  - FIFO write at the end of T+1;
  - evt_valid=1 at T+2 if the FIFO was empty.
- Event outputs:
  - Driven directly from the FIFO head.
  - Held stable while evt_valid && !evt_ready.
- Back-to-back pops are allowed every cycle.
- Simultaneous push and pop on an empty FIFO: no pop occurs (valid=0); the push lands.
- clrn asserted mid-frame or mid-sequence: all state is lost immediately; no partial event is emitted after release.

## Structure
- Package ps2_pkg holds:
  - prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0;
  - the FSM state enum;
  - the event struct {repeat, ext, brk, code}.
- Sub-module ps2_frame_rx: synchroniser, edge detect, shifter, parity/stop check, timeout. It outputs byte/byte_vld/err.
- FIFO and FSM are inline in the top module.

## Test plan
- Frames 1C, F0 1C (A press and release) → events {code=1C, break=0, ext=0, repeat=0}, then {1C, break=1}; fifo_count reaches 2 with no consumer.
- Frames E0 75, E0 F0 75 (up arrow) → {75, ext=1, break=0}, then {75, ext=1, break=1}.
- Frames 1C, 1C, 1C, F0 1C, 1C → repeat flags 0, 1, 1, 0 (break), 0.
- Frame 1C with wrong parity → no event, frame_err=1; err_clr for one cycle → frame_err=0; next good frame 1B → event 1B.
- evt_ready=0 with FIFO_DEPTH+1 makes → fifo_count=FIFO_DEPTH, overflow=1, and the first FIFO_DEPTH codes are popped in order.
- Send 5 data bits then stall for TIMEOUT_CYCLES → frame_err=1; a full frame 29 afterward → single event 29.
- clrn pulsed after E0 F0 → the next frame 29 yields {29, ext=0, break=0}.
